// File: rtl/iot_datapath_if.sv
// Byte-stream and result bus between the IoT filter controller and iot_datapath.
// master drives bytes and counters; slave (the datapath) returns results.
interface iot_datapath_if;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic [3:0]   cnt_cycle;
    logic [2:0]   cnt_data;
    logic         out_en;
    logic [127:0] iot_out;

    modport master (
        output in_en, iot_in, fn_sel, cnt_cycle, cnt_data,
        input  out_en, iot_out
    );

    modport slave (
        input  in_en, iot_in, fn_sel, cnt_cycle, cnt_data,
        output out_en, iot_out
    );
endinterface

// File: rtl/iot_datapath.sv
// IoT filter datapath: assembles 16-byte words and applies max/min/avg/extract/exclude
// and, with IOTDF_PEAK_EN defined, the cross-round peak max/min functions.
module iot_datapath #(
    parameter logic [127:0] EXT_LO = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    parameter logic [127:0] EXT_HI = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF
) (
    input logic           clk,
    input logic           rst,
    iot_datapath_if.slave bus
);

    localparam logic [2:0] FN_MAX  = 3'd1;
    localparam logic [2:0] FN_MIN  = 3'd2;
    localparam logic [2:0] FN_AVG  = 3'd3;
    localparam logic [2:0] FN_EXT  = 3'd4;
    localparam logic [2:0] FN_EXC  = 3'd5;
`ifdef IOTDF_PEAK_EN
    localparam logic [2:0] FN_PMAX = 3'd6;
    localparam logic [2:0] FN_PMIN = 3'd7;
`endif

    logic [127:0] w_q;
    logic [127:0] acc_q;
    logic [130:0] sum_q;
    logic         out_en_q;
    logic [127:0] iot_out_q;

    logic [127:0] cw;
    logic         word_edge;
    logic         round_edge;
    logic         first_word;
    logic         use_max;
    logic         use_min;
    logic [127:0] round_val;
    logic [130:0] sum_next;
    logic         peak_take;
    logic         out_take;
    logic [127:0] out_val;

    assign cw         = {w_q[119:0], bus.iot_in};
    assign word_edge  = bus.in_en && (bus.cnt_cycle == 4'd15);
    assign round_edge = word_edge && (bus.cnt_data == 3'd7);
    assign first_word = (bus.cnt_data == 3'd0);

    always_comb begin
        use_max = (bus.fn_sel == FN_MAX);
        use_min = (bus.fn_sel == FN_MIN);
`ifdef IOTDF_PEAK_EN
        use_max = use_max || (bus.fn_sel == FN_PMAX);
        use_min = use_min || (bus.fn_sel == FN_PMIN);
`endif
    end

    // Round result including the word completing this cycle.
    always_comb begin
        round_val = acc_q;
        if (first_word) begin
            round_val = cw;
        end else if (use_max && (cw > acc_q)) begin
            round_val = cw;
        end else if (use_min && (cw < acc_q)) begin
            round_val = cw;
        end
    end

    assign sum_next = first_word ? {3'b000, cw} : (sum_q + {3'b000, cw});

`ifdef IOTDF_PEAK_EN
    logic [127:0] peak_q;
    logic         pv_q;
    logic         peak_better;

    always_comb begin
        peak_better = (bus.fn_sel == FN_PMAX) ? (round_val > peak_q) : (round_val < peak_q);
        peak_take   = round_edge && ((bus.fn_sel == FN_PMAX) || (bus.fn_sel == FN_PMIN)) &&
                      (!pv_q || peak_better);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
            pv_q   <= 1'b0;
        end else if (peak_take) begin
            peak_q <= round_val;
            pv_q   <= 1'b1;
        end
    end
`else
    assign peak_take = 1'b0;
`endif

    always_comb begin
        out_take = 1'b0;
        out_val  = round_val;
        case (bus.fn_sel)
            FN_MAX, FN_MIN: out_take = round_edge;
            FN_AVG: begin
                out_take = round_edge;
                out_val  = sum_next[130:3];
            end
            FN_EXT: begin
                out_take = word_edge && (cw > EXT_LO) && (cw < EXT_HI);
                out_val  = cw;
            end
            FN_EXC: begin
                out_take = word_edge && ((cw < EXT_LO) || (cw > EXT_HI));
                out_val  = cw;
            end
            // Idle, and peak functions (which collapse to idle when not compiled in).
            default: out_take = peak_take;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
        end else if (bus.in_en) begin
            w_q <= cw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (word_edge && (use_max || use_min)) begin
            acc_q <= round_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (word_edge && (bus.fn_sel == FN_AVG)) begin
            sum_q <= sum_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en_q  <= 1'b0;
            iot_out_q <= '0;
        end else begin
            out_en_q <= out_take;
            if (out_take) begin
                iot_out_q <= out_val;
            end
        end
    end

    assign bus.out_en  = out_en_q;
    assign bus.iot_out = iot_out_q;

endmodule

// File: tb/tb_iot_datapath.sv
// Directed self-checking bench for iot_datapath; peak checks follow IOTDF_PEAK_EN.
module tb_iot_datapath;

    localparam logic [127:0] LO = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] HI = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst;
    iot_datapath_if bus ();

    iot_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_checks = 0;
    int           n_fails = 0;
    int           cyc = 0;
    int           pulse_t[$];
    logic [127:0] pulse_v[$];
    int           double_cnt = 0;
    logic         prev_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_en === 1'b1) begin
            pulse_t.push_back(cyc);
            pulse_v.push_back(bus.iot_out);
            if (prev_en) double_cnt++;
        end
        prev_en = (bus.out_en === 1'b1);
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [127:0] top(input logic [7:0] b);
        return {b, 120'h0};
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.in_en     = 1'b0;
            bus.iot_in    = 8'h00;
            bus.cnt_cycle = 4'd0;
        end
    endtask

    // Sends 16 bytes MSB-first; optionally stalls gap_len cycles before byte gap_at.
    task automatic send_word(input logic [127:0] word, input logic [2:0] didx,
                             input int gap_at, input int gap_len);
        logic [127:0] tmp;
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    bus.in_en     = 1'b0;
                    bus.iot_in    = 8'hA5;
                    bus.cnt_cycle = 4'(i);
                    bus.cnt_data  = didx;
                end
            end
            tmp = word << (8 * i);
            @(negedge clk);
            bus.in_en     = 1'b1;
            bus.iot_in    = tmp[127:120];
            bus.cnt_cycle = 4'(i);
            bus.cnt_data  = didx;
        end
    endtask

    task automatic send_round(input logic [7:0][127:0] ws);
        for (int i = 0; i < 8; i++) send_word(ws[i], 3'(i), -1, 0);
    endtask

    task automatic do_reset(input logic [2:0] fn);
        @(negedge clk);
        bus.in_en     = 1'b0;
        bus.cnt_cycle = 4'd0;
        bus.cnt_data  = 3'd0;
        bus.fn_sel    = fn;
        rst           = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_en !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_out_en: got %b want 0", bus.out_en);
            end
        end
        rst = 1'b0;
        pulse_t.delete();
        pulse_v.delete();
        double_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset(3'd0);
        n_checks++;
        if (bus.iot_out !== 128'h0) begin
            n_fails++;
            $display("FAIL reset_iot_out: got %h want 0", bus.iot_out);
        end
    endtask

    task automatic test_idle();
        logic [7:0][127:0] ws;
        do_reset(3'd0);
        for (int i = 0; i < 8; i++) ws[i] = top(8'(8'h11 * i));
        send_round(ws);
        idle(3);
        n_checks++;
        if (pulse_t.size() != 0 || bus.iot_out !== 128'h0) begin
            n_fails++;
            $display("FAIL idle: pulses %0d out %h want 0 pulses out 0", pulse_t.size(), bus.iot_out);
        end
    endtask

    task automatic test_f1_max();
        logic [7:0][127:0] ws;
        do_reset(3'd1);
        for (int i = 0; i < 8; i++) ws[i] = 128'h0;
        ws[0] = top(8'h01);
        ws[1] = top(8'h7F);
        ws[2] = top(8'h05);
        for (int i = 0; i < 7; i++) send_word(ws[i], 3'(i), -1, 0);
        n_checks++;
        if (pulse_t.size() != 0) begin
            n_fails++;
            $display("FAIL f1_early: got %0d pulses want 0", pulse_t.size());
        end
        send_word(ws[7], 3'd7, -1, 0);
        @(negedge clk);
        bus.in_en = 1'b0;
        n_checks++;
        if (bus.out_en !== 1'b1 || bus.iot_out !== top(8'h7F)) begin
            n_fails++;
            $display("FAIL f1_result: got en %b out %h want en 1 out %h",
                     bus.out_en, bus.iot_out, top(8'h7F));
        end
        idle(4);
        n_checks++;
        if (pulse_t.size() != 1) begin
            n_fails++;
            $display("FAIL f1_pulses: got %0d want 1", pulse_t.size());
        end
    endtask

    task automatic test_f2_reset_mid();
        logic [7:0][127:0] ws;
        logic [127:0] tmp;
        do_reset(3'd2);
        for (int i = 0; i < 3; i++) send_word(top(8'h01), 3'(i), -1, 0);
        tmp = top(8'h02);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.in_en     = 1'b1;
            bus.iot_in    = tmp[127:120];
            bus.cnt_cycle = 4'(i);
            bus.cnt_data  = 3'd3;
            tmp           = tmp << 8;
        end
        n_checks++;
        if (pulse_t.size() != 0) begin
            n_fails++;
            $display("FAIL f2_partial: got %0d pulses want 0", pulse_t.size());
        end
        do_reset(3'd2);
        n_checks++;
        if (bus.iot_out !== 128'h0) begin
            n_fails++;
            $display("FAIL f2_reset_out: got %h want 0", bus.iot_out);
        end
        ws[0] = top(8'h30); ws[1] = top(8'h20); ws[2] = top(8'h25); ws[3] = top(8'h40);
        ws[4] = top(8'h50); ws[5] = top(8'h60); ws[6] = top(8'h70); ws[7] = top(8'h80);
        send_round(ws);
        idle(3);
        n_checks++;
        if (pulse_t.size() != 1 || bus.iot_out !== top(8'h20)) begin
            n_fails++;
            $display("FAIL f2_fresh: got %0d pulses out %h want 1 pulse out %h",
                     pulse_t.size(), bus.iot_out, top(8'h20));
        end
    endtask

    task automatic test_f3_avg();
        logic [7:0][127:0] ws;
        do_reset(3'd3);
        for (int i = 0; i < 8; i++) ws[i] = 128'h8;
        ws[4] = 128'h10;
        for (int i = 0; i < 7; i++) send_word(ws[i], 3'(i), -1, 0);
        n_checks++;
        if (pulse_t.size() != 0) begin
            n_fails++;
            $display("FAIL f3_early: got %0d pulses want 0", pulse_t.size());
        end
        send_word(ws[7], 3'd7, -1, 0);
        @(negedge clk);
        bus.in_en = 1'b0;
        n_checks++;
        if (bus.out_en !== 1'b1 || bus.iot_out !== 128'h9) begin
            n_fails++;
            $display("FAIL f3_avg: got en %b out %h want en 1 out 9", bus.out_en, bus.iot_out);
        end
        // All-ones words exercise the carry bits of the sum and its clear on word 0.
        for (int i = 0; i < 8; i++) ws[i] = '1;
        send_round(ws);
        idle(3);
        n_checks++;
        if (pulse_t.size() != 2 || bus.iot_out !== {128{1'b1}}) begin
            n_fails++;
            $display("FAIL f3_wide: got %0d pulses out %h want 2 pulses out all-ones",
                     pulse_t.size(), bus.iot_out);
        end
    endtask

    task automatic test_f4_extract();
        do_reset(3'd4);
        send_word(LO, 3'd0, -1, 0);
        send_word(top(8'h80), 3'd1, -1, 0);
        send_word(top(8'hB0), 3'd2, -1, 0);
        send_word(HI, 3'd3, -1, 0);
        idle(2);
        n_checks++;
        if (pulse_t.size() != 1 || bus.iot_out !== top(8'h80)) begin
            n_fails++;
            $display("FAIL f4_bounds: got %0d pulses out %h want 1 pulse out %h",
                     pulse_t.size(), bus.iot_out, top(8'h80));
        end
    endtask

    task automatic test_back_to_back();
        do_reset(3'd4);
        send_word(top(8'h90), 3'd0, -1, 0);
        send_word(LO + 128'd1, 3'd1, -1, 0);
        idle(3);
        n_checks++;
        if (pulse_t.size() != 2 || double_cnt != 0) begin
            n_fails++;
            $display("FAIL b2b_count: got %0d pulses %0d doubles want 2 pulses 0 doubles",
                     pulse_t.size(), double_cnt);
        end else begin
            n_checks++;
            if (pulse_t[1] - pulse_t[0] != 16 || pulse_v[1] !== LO + 128'd1) begin
                n_fails++;
                $display("FAIL b2b_spacing: got gap %0d out %h want gap 16 out %h",
                         pulse_t[1] - pulse_t[0], pulse_v[1], LO + 128'd1);
            end
        end
    endtask

    task automatic test_f5_exclude();
        do_reset(3'd5);
        send_word(LO, 3'd0, -1, 0);
        send_word(LO - 128'd1, 3'd1, -1, 0);
        send_word(HI, 3'd2, -1, 0);
        send_word(HI + 128'd1, 3'd3, -1, 0);
        send_word(top(8'h80), 3'd4, -1, 0);
        idle(2);
        n_checks++;
        if (pulse_t.size() != 2) begin
            n_fails++;
            $display("FAIL f5_count: got %0d pulses want 2", pulse_t.size());
        end else begin
            n_checks++;
            if (pulse_v[0] !== LO - 128'd1 || pulse_v[1] !== HI + 128'd1) begin
                n_fails++;
                $display("FAIL f5_values: got %h %h want %h %h",
                         pulse_v[0], pulse_v[1], LO - 128'd1, HI + 128'd1);
            end
        end
    endtask

    task automatic test_gap();
        logic [127:0] wa;
        logic [127:0] wb;
        wa = 128'h8011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        wb = 128'h9F01_0203_0405_0607_0809_0A0B_0C0D_0E0F;
        do_reset(3'd4);
        send_word(wa, 3'd0, 8, 3);
        idle(2);
        n_checks++;
        if (pulse_t.size() != 1 || bus.iot_out !== wa) begin
            n_fails++;
            $display("FAIL gap_mid: got %0d pulses out %h want 1 pulse out %h",
                     pulse_t.size(), bus.iot_out, wa);
        end
        // Stall with cnt_cycle held at 15: no edge until the last byte really arrives.
        send_word(wb, 3'd1, 15, 3);
        @(negedge clk);
        bus.in_en = 1'b0;
        n_checks++;
        if (pulse_t.size() != 1 || bus.out_en !== 1'b1 || bus.iot_out !== wb) begin
            n_fails++;
            $display("FAIL gap_last: got %0d prior pulses en %b out %h want 1 en 1 out %h",
                     pulse_t.size(), bus.out_en, bus.iot_out, wb);
        end
        idle(2);
    endtask

    task automatic test_peak();
        logic [7:0][127:0] ws;
        logic [7:0]        mx[4];
        logic [7:0]        mn[3];
        mx[0] = 8'h50; mx[1] = 8'h40; mx[2] = 8'h50; mx[3] = 8'h60;
        mn[0] = 8'h30; mn[1] = 8'h40; mn[2] = 8'h20;
        do_reset(3'd6);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) ws[i] = top(8'h10);
            ws[r + 2] = top(mx[r]);
            send_round(ws);
        end
        idle(3);
`ifdef IOTDF_PEAK_EN
        n_checks++;
        if (pulse_t.size() != 2) begin
            n_fails++;
            $display("FAIL f6_count: got %0d pulses want 2", pulse_t.size());
        end else begin
            n_checks++;
            if (pulse_v[0] !== top(8'h50) || pulse_v[1] !== top(8'h60)) begin
                n_fails++;
                $display("FAIL f6_values: got %h %h want %h %h",
                         pulse_v[0], pulse_v[1], top(8'h50), top(8'h60));
            end
        end
`else
        n_checks++;
        if (pulse_t.size() != 0 || bus.iot_out !== 128'h0) begin
            n_fails++;
            $display("FAIL f6_disabled: got %0d pulses out %h want 0 pulses out 0",
                     pulse_t.size(), bus.iot_out);
        end
`endif
        do_reset(3'd7);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) ws[i] = top(8'hF0);
            ws[7 - r] = top(mn[r]);
            send_round(ws);
        end
        idle(3);
`ifdef IOTDF_PEAK_EN
        n_checks++;
        if (pulse_t.size() != 2) begin
            n_fails++;
            $display("FAIL f7_count: got %0d pulses want 2", pulse_t.size());
        end else begin
            n_checks++;
            if (pulse_v[0] !== top(8'h30) || pulse_v[1] !== top(8'h20)) begin
                n_fails++;
                $display("FAIL f7_values: got %h %h want %h %h",
                         pulse_v[0], pulse_v[1], top(8'h30), top(8'h20));
            end
        end
`else
        n_checks++;
        if (pulse_t.size() != 0 || bus.iot_out !== 128'h0) begin
            n_fails++;
            $display("FAIL f7_disabled: got %0d pulses out %h want 0 pulses out 0",
                     pulse_t.size(), bus.iot_out);
        end
`endif
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_en     = 1'b0;
        bus.iot_in    = 8'h00;
        bus.fn_sel    = 3'd0;
        bus.cnt_cycle = 4'd0;
        bus.cnt_data  = 3'd0;
        test_reset();
        test_idle();
        test_f1_max();
        test_f2_reset_mid();
        test_f3_avg();
        test_f4_extract();
        test_back_to_back();
        test_f5_exclude();
        test_gap();
        test_peak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
